// File: rtl/ccc_lock_reset_seq.sv
// ============================================================================
//  Module      : ccc_lock_reset_seq
//  Description : Lock supervisor and staggered reset sequencer for a fabric
//                clock-conditioning block (CCC/PLL).
//
//                LOCK_IN is synchronised and filtered.
//                NUM_CH active-low domain resets are then released one by one,
//                STAGGER cycles apart, in channel order.
//                Losing lock re-asserts every domain reset on the same edge,
//                bumps a saturating loss counter and re-runs the sequence.
//
//  Ports       : CLK        - system clock, rising edge
//                RESET      - synchronous active-high reset
//                LOCK_IN    - raw CCC LOCK, asynchronous to CLK
//                CH_EN      - per-channel enable; 0 holds the channel in reset
//                RESEQ      - one-cycle request to re-sequence (RUN only)
//                CH_RESET_N - per-domain active-low resets, bit i released i-th
//                READY      - all enabled channels released, lock stable
//                LOSS_CNT   - saturating count of lock-loss events
//                STATE      - FSM state for debug
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccc_lock_reset_seq #(
    parameter int NUM_CH      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 16,
    parameter int STAGGER     = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOCK_IN,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic              RESEQ,
    output logic [NUM_CH-1:0] CH_RESET_N,
    output logic              READY,
    output logic [7:0]        LOSS_CNT,
    output logic [2:0]        STATE
);

    // ------------------------------------------------------------------------
    // Counter widths. Each counter is sized so that its terminal value fits,
    // and never narrower than one bit.
    // ------------------------------------------------------------------------
    localparam int FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER + 1) : 1;
    localparam int STAG_W = (STAGGER > 1)     ? $clog2(STAGGER + 1)     : 1;
    localparam int IDX_W  = (NUM_CH > 1)      ? $clog2(NUM_CH + 1)      : 1;

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3
    } state_t;

    // ------------------------------------------------------------------------
    // LOCK synchroniser.
    // Bit 0 captures the raw input.
    // The top bit is the clean lock_s seen by the FSM.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   lock_s;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], LOCK_IN};
        end
    end

    assign lock_s = sync_ff[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Sequencer state: current registers and their next values
    // ------------------------------------------------------------------------
    state_t              state,      state_nx;
    logic [FILT_W-1:0]   filt_cnt,   filt_nx;
    logic [STAG_W-1:0]   stag_cnt,   stag_nx;
    logic [IDX_W-1:0]    idx,        idx_nx;
    logic [NUM_CH-1:0]   ch_rst_n,   ch_nx;
    logic                ready,      ready_nx;
    logic [7:0]          loss_cnt,   loss_nx;

    // Set when this edge aborts a running sequence.
    // loss_event additionally asks for the loss counter to advance.
    logic                abort_seq;
    logic                loss_event;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= WAIT_LOCK;
            filt_cnt <= '0;
            stag_cnt <= '0;
            idx      <= '0;
            ch_rst_n <= '0;
            ready    <= 1'b0;
            loss_cnt <= '0;
        end else begin
            state    <= state_nx;
            filt_cnt <= filt_nx;
            stag_cnt <= stag_nx;
            idx      <= idx_nx;
            ch_rst_n <= ch_nx;
            ready    <= ready_nx;
            loss_cnt <= loss_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        filt_nx    = filt_cnt;
        stag_nx    = stag_cnt;
        idx_nx     = idx;
        ch_nx      = ch_rst_n;
        ready_nx   = ready;
        loss_nx    = loss_cnt;
        abort_seq  = 1'b0;
        loss_event = 1'b0;

        case (state)
            WAIT_LOCK: begin
                ch_nx    = '0;
                ready_nx = 1'b0;
                if (lock_s) begin
                    state_nx = FILTER;
                    filt_nx  = '0;
                end
            end

            FILTER: begin
                // A dropout here is treated as a glitch.
                // Nothing has been released yet, so no loss is counted.
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                    filt_nx  = '0;
                end else if (filt_cnt == FILT_LAST) begin
                    state_nx = RELEASE;
                    filt_nx  = '0;
                    idx_nx   = '0;
                    stag_nx  = '0;
                end else begin
                    filt_nx = filt_cnt + 1'b1;
                end
            end

            RELEASE: begin
                if (!lock_s) begin
                    abort_seq  = 1'b1;
                    loss_event = 1'b1;
                end else if (stag_cnt == STAG_LAST) begin
                    stag_nx = '0;
                    // A masked channel still uses its slot.
                    // This keeps release timing independent of CH_EN.
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx == IDX_W'(i)) begin
                            ch_nx[i] = CH_EN[i];
                        end
                    end
                    if (idx == IDX_LAST) begin
                        state_nx = RUN;
                        ready_nx = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else begin
                    stag_nx = stag_cnt + 1'b1;
                end
            end

            RUN: begin
                // Lock loss has priority over RESEQ.
                // A simultaneous request therefore counts exactly once.
                if (!lock_s) begin
                    abort_seq  = 1'b1;
                    loss_event = 1'b1;
                end else if (RESEQ) begin
                    abort_seq = 1'b1;
                end else begin
                    ch_nx = CH_EN;
                end
            end

            default: begin
                state_nx = WAIT_LOCK;
                ch_nx    = '0;
                ready_nx = 1'b0;
            end
        endcase

        if (abort_seq) begin
            state_nx = WAIT_LOCK;
            ch_nx    = '0;
            ready_nx = 1'b0;
            filt_nx  = '0;
            stag_nx  = '0;
            idx_nx   = '0;
        end

        if (loss_event && (loss_cnt != 8'hFF)) begin
            loss_nx = loss_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from registers
    // ------------------------------------------------------------------------
    assign CH_RESET_N = ch_rst_n;
    assign READY      = ready;
    assign LOSS_CNT   = loss_cnt;
    assign STATE      = state;

endmodule

`default_nettype wire

// File: tb/tb_ccc_lock_reset_seq.sv
// ============================================================================
//  Module      : tb_ccc_lock_reset_seq
//  Description : Self-checking bench for ccc_lock_reset_seq.
//
//                The reference model tracks only two things:
//                  - whether a sequence is active;
//                  - how many edges have elapsed since the FSM first saw lock.
//                Release points are derived from the elapsed-time formula.
//
//                Directed scenarios add checks against fixed edge numbers.
//                A randomised phase then exercises lock drops, RESEQ,
//                CH_EN changes and RESET.
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccc_lock_reset_seq;

    localparam int NUM_CH      = 3;
    localparam int SYNC_STAGES = 2;
    localparam int LOCK_FILTER = 16;
    localparam int STAGGER     = 8;
    localparam int SEQ_LEN     = LOCK_FILTER + NUM_CH * STAGGER;
    localparam int T_REL0      = SYNC_STAGES + LOCK_FILTER;

    logic              CLK;
    logic              RESET;
    logic              LOCK_IN;
    logic [NUM_CH-1:0] CH_EN;
    logic              RESEQ;
    logic [NUM_CH-1:0] CH_RESET_N;
    logic              READY;
    logic [7:0]        LOSS_CNT;
    logic [2:0]        STATE;

    ccc_lock_reset_seq #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .LOCK_FILTER (LOCK_FILTER),
        .STAGGER     (STAGGER)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .LOCK_IN    (LOCK_IN),
        .CH_EN      (CH_EN),
        .RESEQ      (RESEQ),
        .CH_RESET_N (CH_RESET_N),
        .READY      (READY),
        .LOSS_CNT   (LOSS_CNT),
        .STATE      (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    bit                lk_q[$];     // raw LOCK samples still in flight to the FSM
    bit                m_active;    // a sequence is running (filter/release/run)
    int                m_t;         // edges since the FSM first saw lock
    logic [NUM_CH-1:0] m_ch;
    logic              m_ready;
    int                m_loss;

    task automatic model_reset();
        m_active = 1'b0;
        m_t      = 0;
        m_ch     = '0;
        m_ready  = 1'b0;
        m_loss   = 0;
        lk_q.delete();
        for (int i = 0; i < SYNC_STAGES; i++) lk_q.push_back(1'b0);
    endtask

    task automatic model_drop(input bit counted);
        m_active = 1'b0;
        m_ch     = '0;
        m_ready  = 1'b0;
        if (counted && m_loss < 255) m_loss++;
    endtask

    task automatic model_edge(input logic lk, input logic [NUM_CH-1:0] en,
                              input logic rs, input logic rst);
        bit seen;
        int ch;
        if (rst) begin
            model_reset();
            return;
        end
        seen = lk_q.pop_front();
        lk_q.push_back(lk);
        if (!m_active) begin
            m_ch    = '0;
            m_ready = 1'b0;
            if (seen) begin
                m_active = 1'b1;
                m_t      = 0;
            end
        end else if (m_t < LOCK_FILTER) begin
            if (!seen) m_active = 1'b0;
            else       m_t++;
        end else if (m_t < SEQ_LEN) begin
            if (!seen) begin
                model_drop(1'b1);
            end else begin
                m_t++;
                if ((m_t - LOCK_FILTER) % STAGGER == 0) begin
                    ch       = (m_t - LOCK_FILTER) / STAGGER - 1;
                    m_ch[ch] = en[ch];
                    if (m_t == SEQ_LEN) m_ready = 1'b1;
                end
            end
        end else begin
            if (!seen)   model_drop(1'b1);
            else if (rs) model_drop(1'b0);
            else         m_ch = en;
        end
    endtask

    function automatic int model_state();
        if (!m_active)              return 0;
        else if (m_t < LOCK_FILTER) return 1;
        else if (m_t < SEQ_LEN)     return 2;
        else                        return 3;
    endfunction

    task automatic compare_model();
        check("m_ch_reset_n", 32'(CH_RESET_N), 32'(m_ch));
        check("m_ready",      32'(READY),      32'(m_ready));
        check("m_loss_cnt",   32'(LOSS_CNT),   32'(m_loss));
        check("m_state",      32'(STATE),      32'(model_state()));
    endtask

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    // Drive at the falling edge, step the model on the rising edge,
    // then sample 1 time unit later.
    task automatic step(input logic lk, input logic [NUM_CH-1:0] en,
                        input logic rs, input logic rst);
        @(negedge CLK);
        LOCK_IN = lk;
        CH_EN   = en;
        RESEQ   = rs;
        RESET   = rst;
        @(posedge CLK);
        model_edge(lk, en, rs, rst);
        #1;
        compare_model();
    endtask

    // Lock held high from edge 0 of a fresh sequence.
    // Checks against fixed edge numbers.
    task automatic run_nominal(input logic [NUM_CH-1:0] en);
        logic [NUM_CH-1:0] lo_mask;
        int                rel;
        for (int k = 0; k <= T_REL0 + NUM_CH * STAGGER + 2; k++) begin
            step(1'b1, en, 1'b0, 1'b0);
            if (k == SYNC_STAGES - 1) check("nom_state_wait",   32'(STATE), 32'd0);
            if (k == SYNC_STAGES)     check("nom_state_filter", 32'(STATE), 32'd1);
            if (k == T_REL0 - 1)      check("nom_state_filt_end", 32'(STATE), 32'd1);
            if (k == T_REL0)          check("nom_state_release",  32'(STATE), 32'd2);
            for (int i = 0; i < NUM_CH; i++) begin
                rel     = T_REL0 + (i + 1) * STAGGER;
                lo_mask = NUM_CH'((1 << i) - 1);
                if (k == rel - 1) check("nom_ch_before", 32'(CH_RESET_N), 32'(en & lo_mask));
                if (k == rel)     check("nom_ch_at",     32'(CH_RESET_N), 32'(en & ((lo_mask << 1) | 1'b1)));
            end
            if (k == T_REL0 + NUM_CH * STAGGER - 1) begin
                check("nom_ready_early", 32'(READY), 32'd0);
                check("nom_state_rel_end", 32'(STATE), 32'd2);
            end
            if (k == T_REL0 + NUM_CH * STAGGER) begin
                check("nom_ready", 32'(READY), 32'd1);
                check("nom_state_run", 32'(STATE), 32'd3);
            end
        end
    endtask

    initial begin
        logic [NUM_CH-1:0] en;
        logic              lk;
        logic              rs;
        logic              rst;
        int                hold;

        model_reset();
        RESET   = 1'b1;
        LOCK_IN = 1'b0;
        CH_EN   = '1;
        RESEQ   = 1'b0;

        // Reset state
        repeat (3) step(1'b0, '1, 1'b0, 1'b1);
        check("rst_ch",    32'(CH_RESET_N), 32'd0);
        check("rst_ready", 32'(READY),      32'd0);
        check("rst_loss",  32'(LOSS_CNT),   32'd0);
        check("rst_state", 32'(STATE),      32'd0);

        // 1: nominal sequence
        run_nominal('1);
        check("nom_loss", 32'(LOSS_CNT), 32'd0);

        // 3: lock loss in RUN; outputs clear two edges after the drop
        repeat (5) step(1'b1, '1, 1'b0, 1'b0);
        step(1'b0, '1, 1'b0, 1'b0);
        step(1'b0, '1, 1'b0, 1'b0);
        check("loss_ch_hold", 32'(CH_RESET_N), 32'h7);
        step(1'b0, '1, 1'b0, 1'b0);
        check("loss_ch",    32'(CH_RESET_N), 32'd0);
        check("loss_ready", 32'(READY),      32'd0);
        check("loss_cnt",   32'(LOSS_CNT),   32'd1);
        repeat (3) step(1'b0, '1, 1'b0, 1'b0);
        run_nominal('1);
        check("relock_loss", 32'(LOSS_CNT), 32'd1);

        // 2: one-cycle glitch restarts the filter
        step(1'b0, '1, 1'b0, 1'b1);
        for (int k = 0; k <= 11 + 27; k++) begin
            step((k == 10) ? 1'b0 : 1'b1, '1, 1'b0, 1'b0);
            if (k < 37)  check("glitch_no_rel", 32'(CH_RESET_N), 32'd0);
            if (k == 37) check("glitch_rel0",   32'(CH_RESET_N), 32'd1);
        end
        check("glitch_loss", 32'(LOSS_CNT), 32'd0);

        // 4: loss during RELEASE, seen by the FSM at edge 30
        step(1'b0, '1, 1'b0, 1'b1);
        for (int k = 0; k <= 30; k++) begin
            step((k < 28) ? 1'b1 : 1'b0, '1, 1'b0, 1'b0);
            if (k == 29) check("rel_loss_pre", 32'(CH_RESET_N), 32'd1);
        end
        check("rel_loss_ch",    32'(CH_RESET_N), 32'd0);
        check("rel_loss_cnt",   32'(LOSS_CNT),   32'd1);
        check("rel_loss_state", 32'(STATE),      32'd0);

        // 5: masking, then enable the masked channel in RUN
        step(1'b0, '1, 1'b0, 1'b1);
        run_nominal(3'b101);
        step(1'b1, 3'b111, 1'b0, 1'b0);
        check("mask_enable", 32'(CH_RESET_N), 32'h7);

        // 6: RESEQ in RUN, then a full re-sequence
        step(1'b1, '1, 1'b1, 1'b0);
        check("reseq_ch",   32'(CH_RESET_N), 32'd0);
        check("reseq_loss", 32'(LOSS_CNT),   32'd0);
        for (int j = 1; j <= 42; j++) begin
            step(1'b1, '1, 1'b0, 1'b0);
            if (j == 25) check("reseq_rel0",  32'(CH_RESET_N), 32'd1);
            if (j == 40) check("reseq_rdy_n", 32'(READY),      32'd0);
            if (j == 41) check("reseq_rdy",   32'(READY),      32'd1);
        end

        // RESET while in RELEASE clears everything, including LOSS_CNT
        repeat (3) step(1'b0, '1, 1'b0, 1'b0);
        repeat (3) step(1'b0, '1, 1'b0, 1'b0);
        repeat (22) step(1'b1, '1, 1'b0, 1'b0);
        check("rr_state_pre", 32'(STATE), 32'd2);
        step(1'b1, '1, 1'b0, 1'b1);
        check("rr_ch",    32'(CH_RESET_N), 32'd0);
        check("rr_ready", 32'(READY),      32'd0);
        check("rr_loss",  32'(LOSS_CNT),   32'd0);
        check("rr_state", 32'(STATE),      32'd0);

        // Randomised phase
        lk   = 1'b0;
        en   = '1;
        hold = 0;
        for (int c = 0; c < 5000; c++) begin
            if (hold == 0) begin
                lk   = ~lk;
                hold = lk ? int'($urandom_range(80, 1)) : int'($urandom_range(6, 1));
            end
            hold--;
            if ($urandom_range(19, 0) == 0) en = NUM_CH'($urandom);
            rs  = ($urandom_range(39, 0) == 0);
            rst = ($urandom_range(599, 0) == 0);
            step(lk, en, rs, rst);
        end

        // 3 (cont.): LOSS_CNT saturates at 255
        step(1'b0, '1, 1'b0, 1'b1);
        for (int r = 0; r < 300; r++) begin
            repeat (22) step(1'b1, '1, 1'b0, 1'b0);
            repeat (4)  step(1'b0, '1, 1'b0, 1'b0);
        end
        check("sat_loss", 32'(LOSS_CNT), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
